sram_ctrl_2048_8: RTL and testbench
===================================

SRAM_CTRL_2048_8 -- requirements
Module: sram_ctrl_2048_8

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 8, data width.
REQ-002 SHALL have parameter ADDR_SIZE, default 11, address width ({row[6:0], col[3:0]}).
REQ-003 SHALL have parameter WR_PULSE, default 4, number of cycles sram_we_b is held low (min 1).
REQ-004 SHALL have parameter RD_CYCLES, default 3, number of cycles sram_oe_b is held low before capture (min 1).
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port req_valid  input  1  host request present.
REQ-008 SHALL have port req_ready  output  1  controller can accept a request.
REQ-009 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-010 SHALL have port req_addr  input  ADDR_SIZE  request address.
REQ-011 SHALL have port req_wdata  input  WORD_SIZE  write data.
REQ-012 SHALL have port rsp_valid  output  1  one-cycle pulse, read data valid.
REQ-013 SHALL have port rsp_rdata  output  WORD_SIZE  read data, held until the next read completes.
REQ-014 SHALL have port wr_done  output  1  one-cycle pulse, write cycle finished.
REQ-015 SHALL have port sram_addr  output  ADDR_SIZE  SRAM address.
REQ-016 SHALL have port sram_cs_b  output  1  SRAM chip select, active low.
REQ-017 SHALL have port sram_we_b  output  1  SRAM write enable, active low.
REQ-018 SHALL have port sram_oe_b  output  1  SRAM output enable, active low.
REQ-019 SHALL have port sram_dq  inout  WORD_SIZE  bidirectional SRAM data bus; high-Z when not driving.

Function
REQ-020 SHALL implement the FSM states IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_ACCESS and RD_TURN.
REQ-021 SHALL assert req_ready only in IDLE; a request is accepted on a clock edge where req_valid and req_ready are both 1, and req_addr/req_we/req_wdata are latched at that edge.
REQ-022 SHALL follow the write path IDLE -> WR_SETUP (1 cycle: cs_b=0, we_b=1, dq driven) -> WR_PULSE (WR_PULSE cycles, we_b=0) -> WR_HOLD (1 cycle, we_b=1, dq still driven, wr_done=1) -> IDLE.
REQ-023 SHALL follow the read path IDLE -> RD_ACCESS (RD_CYCLES cycles: cs_b=0, oe_b=0, dq high-Z) -> RD_TURN (1 cycle: oe_b=1, dq high-Z) -> IDLE.
REQ-024 SHALL, on the edge leaving RD_ACCESS, capture sram_dq into rsp_rdata, and SHALL assert rsp_valid for exactly the RD_TURN cycle.
REQ-025 SHALL hold sram_addr constant from WR_SETUP/RD_ACCESS entry through WR_HOLD/RD_TURN inclusive.
REQ-026 SHALL have a write occupancy of WR_PULSE+2 cycles and a read occupancy of RD_CYCLES+1 cycles, with req_ready returning the cycle after.
REQ-027 SHALL drive sram_cs_b=1, sram_we_b=1 and sram_oe_b=1 in IDLE.
REQ-028 SHALL never assert sram_we_b and sram_oe_b low simultaneously.
REQ-029 SHALL never drive sram_dq while sram_oe_b=0, nor in the cycle immediately after sram_oe_b rises.
REQ-030 SHALL source all sram_* control outputs and the dq output enable directly from flops, so they are glitch-free.
REQ-031 SHALL ignore req_valid while req_ready=0; back-to-back requests SHALL each incur one IDLE cycle.
REQ-032 SHALL load the wait counter with the state length minus 1 on state entry, and SHALL advance the state when the counter reaches 0.

Reset
REQ-033 SHALL, while rst=1 at a clock edge, set state=IDLE, req_ready=0, rsp_valid=0, wr_done=0, rsp_rdata=0, sram_addr=0, cs_b/we_b/oe_b=1, and release dq.
REQ-034 SHALL set req_ready=1 on the first edge after rst deasserts.
REQ-035 SHALL, on reset mid-operation, abort the transaction: we_b/oe_b go high at that edge, no rsp_valid or wr_done is issued, and SRAM contents at the aborted address are undefined.

Structure
REQ-036 SHALL place the state enum and the default timing constants in a shared package, sram_ctrl_pkg.
REQ-037 SHALL implement the wait counter as the single sub-module sram_wait_cnt (load, decrement, zero flag).

Verification
REQ-038 SHALL verify a write of addr 0x010, data 0x01 -> we_b low for exactly 4 cycles, dq=0x01 from WR_SETUP through WR_HOLD, wr_done pulse at cycle 6, and model RAM_2048_8 holds 0x01 at row 1, col 0.
REQ-039 SHALL verify a read of addr 0x010 after that write -> oe_b low for 3 cycles, rsp_valid for 1 cycle with rsp_rdata=0x01, dq not driven by the controller.
REQ-040 SHALL verify walking ones: write {0x01,0x02,...,0x80} rotating over 128 rows x 16 columns, then read back all 2048 words -> every word matches and there are 0 mismatches.
REQ-041 SHALL verify a write immediately followed by a read, with req_valid held high -> exactly one IDLE cycle between them, and no cycle where dq is driven while oe_b=0.
REQ-042 SHALL verify rst asserted in the 2nd WR_PULSE cycle -> we_b=1 at that edge, no wr_done, and req_ready=1 on the edge after rst falls.
REQ-043 SHALL verify, throughout all runs, that an assertion checking we_b|oe_b==1 never fires.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared FSM state encoding and default timing for the 2048x8 async SRAM controller.
package sram_ctrl_pkg;

  localparam int DEF_WORD_SIZE = 8;
  localparam int DEF_ADDR_SIZE = 11;
  localparam int DEF_WR_PULSE  = 4;
  localparam int DEF_RD_CYCLES = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_RD_ACCESS,
    ST_RD_TURN
  } state_e;

  // Counter width able to hold the longest state length minus one.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// Loadable down-counter that parks at zero; zero flag marks the last cycle of a state.
module sram_wait_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sram_ctrl_2048_8.sv
// Host-request to asynchronous SRAM controller with fixed write-pulse and read-access timing.
module sram_ctrl_2048_8
  import sram_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int WR_PULSE  = DEF_WR_PULSE,
  parameter int RD_CYCLES = DEF_RD_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [WORD_SIZE-1:0] rsp_rdata,
  output logic                 wr_done,
  output logic [ADDR_SIZE-1:0] sram_addr,
  output logic                 sram_cs_b,
  output logic                 sram_we_b,
  output logic                 sram_oe_b,
  inout  wire  [WORD_SIZE-1:0] sram_dq
);

  localparam int CNT_W = cnt_width(WR_PULSE, RD_CYCLES);

  state_e               state, nxt;
  logic                 accept;
  logic                 cnt_load, cnt_zero;
  logic [CNT_W-1:0]     cnt_val;
  logic [WORD_SIZE-1:0] wdata_q;
  logic                 dq_oe;

  assign accept = req_valid & req_ready;

  sram_wait_cnt #(.W(CNT_W)) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt      = state;
    cnt_load = 1'b0;
    cnt_val  = '0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          cnt_load = 1'b1;
          if (req_we) begin
            nxt = ST_WR_SETUP;
          end else begin
            nxt     = ST_RD_ACCESS;
            cnt_val = CNT_W'(RD_CYCLES - 1);
          end
        end
      end
      ST_WR_SETUP: begin
        if (cnt_zero) begin
          nxt      = ST_WR_PULSE;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(WR_PULSE - 1);
        end
      end
      ST_WR_PULSE: begin
        if (cnt_zero) begin
          nxt      = ST_WR_HOLD;
          cnt_load = 1'b1;
        end
      end
      ST_WR_HOLD:   if (cnt_zero) nxt = ST_IDLE;
      ST_RD_ACCESS: begin
        if (cnt_zero) begin
          nxt      = ST_RD_TURN;
          cnt_load = 1'b1;
        end
      end
      ST_RD_TURN:   if (cnt_zero) nxt = ST_IDLE;
      default:      nxt = ST_IDLE;
    endcase
  end

  // Pin-level outputs are registered from the next state so each pin comes straight off a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      wr_done   <= 1'b0;
      rsp_rdata <= '0;
      sram_addr <= '0;
      sram_cs_b <= 1'b1;
      sram_we_b <= 1'b1;
      sram_oe_b <= 1'b1;
      dq_oe     <= 1'b0;
      wdata_q   <= '0;
    end else begin
      req_ready <= (nxt == ST_IDLE);
      rsp_valid <= (nxt == ST_RD_TURN);
      wr_done   <= (nxt == ST_WR_HOLD);
      sram_cs_b <= (nxt == ST_IDLE);
      sram_we_b <= (nxt != ST_WR_PULSE);
      sram_oe_b <= (nxt != ST_RD_ACCESS);
      dq_oe     <= (nxt == ST_WR_SETUP) || (nxt == ST_WR_PULSE) || (nxt == ST_WR_HOLD);
      if (accept) begin
        sram_addr <= req_addr;
        wdata_q   <= req_wdata;
      end
      if ((state == ST_RD_ACCESS) && (nxt == ST_RD_TURN))
        rsp_rdata <= sram_dq;
    end
  end

  assign sram_dq = dq_oe ? wdata_q : 'z;

endmodule

// File: tb/tb_sram_ctrl_2048_8.sv
// Self-checking bench: SRAM pin model, reference memory, vector table, random ops and corner sequences.
module tb_sram_ctrl_2048_8;

  localparam int WS  = 8;
  localparam int AS  = 11;
  localparam int WRP = 4;
  localparam int RDC = 3;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AS-1:0] req_addr;
  logic [WS-1:0] req_wdata;
  logic          rsp_valid;
  logic [WS-1:0] rsp_rdata;
  logic          wr_done;
  logic [AS-1:0] sram_addr;
  logic          sram_cs_b;
  logic          sram_we_b;
  logic          sram_oe_b;
  wire  [WS-1:0] sram_dq;

  int checks = 0;
  int errors = 0;
  int overlap_cnt = 0;
  int cont_cnt = 0;

  logic [WS-1:0] mem     [0:2047] = '{default: '0};
  logic [WS-1:0] ref_mem [0:2047] = '{default: '0};

  sram_ctrl_2048_8 #(
    .WORD_SIZE (WS),
    .ADDR_SIZE (AS),
    .WR_PULSE  (WRP),
    .RD_CYCLES (RDC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .wr_done   (wr_done),
    .sram_addr (sram_addr),
    .sram_cs_b (sram_cs_b),
    .sram_we_b (sram_we_b),
    .sram_oe_b (sram_oe_b),
    .sram_dq   (sram_dq)
  );

  // RAM_2048_8 pin model: drives the bus while selected and output-enabled, stores while we_b is low.
  assign sram_dq = (!sram_cs_b && !sram_oe_b) ? mem[sram_addr] : 'z;
  always @(posedge clk)
    if (!sram_cs_b && !sram_we_b) mem[sram_addr] <= sram_dq;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      assert (sram_we_b | sram_oe_b) else $error("FAIL we_oe_overlap we_b=%b oe_b=%b", sram_we_b, sram_oe_b);
      if (!(sram_we_b | sram_oe_b)) overlap_cnt++;
      if (!sram_cs_b && !sram_oe_b && (sram_dq !== mem[sram_addr])) cont_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction from IDLE back to IDLE, with timing derived from the pulse/access counts.
  task automatic do_txn(input bit we, input logic [AS-1:0] addr, input logic [WS-1:0] wdata,
                        input int gap, output logic [WS-1:0] rdata);
    int w, occ, we_low, oe_low, done_n, done_cyc, rv_n, rv_cyc;
    int addr_bad, dq_bad, cs_bad, rdy_bad;
    repeat (gap) tick();
    w = 0;
    while (!req_ready && w < 20) begin tick(); w++; end
    check("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = AS'($urandom);
    req_wdata = WS'($urandom);
    occ = we ? WRP + 2 : RDC + 1;
    we_low = 0; oe_low = 0; done_n = 0; done_cyc = 0; rv_n = 0; rv_cyc = 0;
    addr_bad = 0; dq_bad = 0; cs_bad = 0; rdy_bad = 0; rdata = '0;
    for (int c = 1; c <= occ; c++) begin
      if (!sram_we_b) we_low++;
      if (!sram_oe_b) oe_low++;
      if (wr_done) begin done_n++; done_cyc = c; end
      if (rsp_valid) begin rv_n++; rv_cyc = c; rdata = rsp_rdata; end
      if (sram_addr !== addr) addr_bad++;
      if (sram_cs_b !== 1'b0) cs_bad++;
      if (req_ready) rdy_bad++;
      if (we && sram_dq !== wdata) dq_bad++;
      if (!we && !sram_oe_b && sram_dq !== ref_mem[addr]) dq_bad++;
      if (c < occ) tick();
    end
    tick();
    check("idle_ready", 32'(req_ready), 32'd1);
    check("idle_pins", {29'd0, sram_cs_b, sram_we_b, sram_oe_b}, 32'd7);
    check("addr_stable_bad", 32'(addr_bad), 32'd0);
    check("cs_low_bad", 32'(cs_bad), 32'd0);
    check("busy_ready_bad", 32'(rdy_bad), 32'd0);
    check("dq_bad", 32'(dq_bad), 32'd0);
    if (we) begin
      ref_mem[addr] = wdata;
      check("wr_we_low_cycles", 32'(we_low), 32'(WRP));
      check("wr_oe_low_cycles", 32'(oe_low), 32'd0);
      check("wr_done_count", 32'(done_n), 32'd1);
      check("wr_done_cycle", 32'(done_cyc), 32'(WRP + 2));
      check("ram_model_word", 32'(mem[addr]), 32'(wdata));
    end else begin
      check("rd_oe_low_cycles", 32'(oe_low), 32'(RDC));
      check("rd_we_low_cycles", 32'(we_low), 32'd0);
      check("rd_valid_count", 32'(rv_n), 32'd1);
      check("rd_valid_cycle", 32'(rv_cyc), 32'(RDC + 1));
      check("rd_data", 32'(rdata), 32'(ref_mem[addr]));
    end
  endtask

  typedef struct {
    bit            we;
    logic [AS-1:0] addr;
    logic [WS-1:0] wdata;
    logic [WS-1:0] exp_rdata;
  } vec_t;

  vec_t vt [8];

  initial begin
    logic [WS-1:0] rd;
    int            cyc, ready_cnt, first_oe, rv_seen, done_seen, walk_mism;
    logic [WS-1:0] exp_w;

    vt[0] = '{1'b1, 11'h010, 8'h01, 8'h00};
    vt[1] = '{1'b0, 11'h010, 8'h00, 8'h01};
    vt[2] = '{1'b1, 11'h7FF, 8'hFF, 8'h00};
    vt[3] = '{1'b0, 11'h7FF, 8'h00, 8'hFF};
    vt[4] = '{1'b1, 11'h000, 8'h5A, 8'h00};
    vt[5] = '{1'b0, 11'h000, 8'h00, 8'h5A};
    vt[6] = '{1'b0, 11'h010, 8'h00, 8'h01};
    vt[7] = '{1'b0, 11'h123, 8'h00, 8'h00};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) tick();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_pins", {29'd0, sram_cs_b, sram_we_b, sram_oe_b}, 32'd7);
    check("rst_valid_done", {30'd0, rsp_valid, wr_done}, 32'd0);
    check("rst_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", 32'(req_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      do_txn(vt[i].we, vt[i].addr, vt[i].wdata, 0, rd);
      if (i == 0) check("ram_row1_col0", 32'(mem[{7'd1, 4'd0}]), 32'h01);
      if (!vt[i].we) check("vec_rdata", 32'(rd), 32'(vt[i].exp_rdata));
    end

    // Write then read with req_valid held high: exactly one ready cycle between the two.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 11'h155; req_wdata = 8'hA5;
    tick();
    req_we = 1'b0;
    cyc = 0; ready_cnt = 0; first_oe = 0; rv_seen = 0; rd = '0;
    while (rv_seen == 0 && cyc < 30) begin
      cyc++;
      if (req_ready) ready_cnt++;
      if (!sram_oe_b && first_oe == 0) begin first_oe = cyc; req_valid = 1'b0; end
      if (rsp_valid) begin rv_seen = cyc; rd = rsp_rdata; end
      if (rv_seen == 0) tick();
    end
    tick();
    ref_mem[11'h155] = 8'hA5;
    check("b2b_timeout", 32'(rv_seen != 0), 32'd1);
    check("b2b_idle_cycles", 32'(ready_cnt), 32'd1);
    check("b2b_read_start", 32'(first_oe), 32'(WRP + 4));
    check("b2b_rsp_cycle", 32'(rv_seen), 32'(WRP + 4 + RDC));
    check("b2b_rdata", 32'(rd), 32'hA5);

    // Reset during the second write-pulse cycle aborts the write.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 11'h2AA; req_wdata = 8'h3C;
    tick();
    req_valid = 1'b0;
    done_seen = 0;
    tick();
    if (wr_done) done_seen++;
    tick();
    if (wr_done) done_seen++;
    check("abort_pre_we", 32'(sram_we_b), 32'd0);
    rst = 1'b1;
    tick();
    if (wr_done) done_seen++;
    check("abort_we_high", 32'(sram_we_b), 32'd1);
    check("abort_cs_high", 32'(sram_cs_b), 32'd1);
    check("abort_ready_low", 32'(req_ready), 32'd0);
    rst = 1'b0;
    tick();
    if (wr_done | rsp_valid) done_seen++;
    check("abort_ready_after", 32'(req_ready), 32'd1);
    check("abort_no_done", 32'(done_seen), 32'd0);
    do_txn(1'b1, 11'h2AA, 8'hC3, 0, rd);
    do_txn(1'b0, 11'h2AA, 8'h00, 0, rd);

    for (int i = 0; i < 300; i++)
      do_txn(1'($urandom_range(0, 1)), AS'($urandom_range(0, 2047)), WS'($urandom),
             int'($urandom_range(0, 2)), rd);

    // Walking ones across every row and column, then full readback.
    for (int i = 0; i < 2048; i++) begin
      exp_w = WS'(1 << (i % 8));
      do_txn(1'b1, AS'(i), exp_w, 0, rd);
    end
    walk_mism = 0;
    for (int i = 0; i < 2048; i++) begin
      exp_w = WS'(1 << (i % 8));
      do_txn(1'b0, AS'(i), 8'h00, 0, rd);
      if (rd !== exp_w) walk_mism++;
    end
    check("walk_mismatches", 32'(walk_mism), 32'd0);

    check("we_oe_overlap_count", 32'(overlap_cnt), 32'd0);
    check("dq_contention_count", 32'(cont_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
